// File: rtl/calc_launcher.sv
// calc_launcher: initiator-side sequencer for one compute engine.
//
// Accepts a job on an upstream valid/ready port, pulses the engine's start,
// waits for a fresh engine valid (rejecting a valid left high by the previous
// job), captures the result with its latency, and hands it downstream on a
// valid/ready port. A job whose result never arrives is aborted after
// TIMEOUT_CYC cycles and reported with rsp_timeout=1 and rsp_data=0.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_valid    upstream job request          / req_ready   launcher can accept
//   eng_start    single-cycle start pulse to the engine
//   eng_busy     engine busy                   / eng_valid   engine result valid
//   eng_result   engine result (DATA_W)
//   rsp_valid    response available            / rsp_ready   downstream accepts
//   rsp_data     captured result (0 on timeout)
//   rsp_timeout  response is a timeout abort
//   rsp_cycles   cycles from eng_start to valid acceptance (or timeout)
//   idle         launcher is idle
module calc_launcher #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              eng_start,
    input  logic              eng_busy,
    input  logic              eng_valid,
    input  logic [DATA_W-1:0] eng_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic [CNT_W-1:0]  rsp_cycles,
    output logic              idle
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HOLD} state_t;

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYC);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] counter;
    logic             armed;
    logic             in_run;
    logic             complete;
    logic             expire;

    // A valid only counts once the engine has shown it is working on this job
    // (busy seen, or valid seen low since launch). A valid still high from the
    // previous job with busy low is therefore ignored.
    assign in_run   = (state == RUN);
    assign complete = in_run && eng_valid && (armed || eng_busy);
    assign expire   = in_run && !complete && (counter == TMO_CNT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)           state_nxt = LAUNCH;
            LAUNCH:                           state_nxt = RUN;
            RUN:     if (complete || expire)  state_nxt = HOLD;
            HOLD:    if (rsp_ready)           state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Combinational outputs decoded from the current state
    always_comb begin
        req_ready = (state == IDLE);
        idle      = (state == IDLE);
    end

    // Datapath and registered handshake outputs. eng_start and rsp_valid are
    // flops loaded from the next state so they are glitch-free and track
    // LAUNCH / HOLD cycle-for-cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            counter     <= '0;
            armed       <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            rsp_cycles  <= '0;
        end else begin
            eng_start <= (state_nxt == LAUNCH);
            rsp_valid <= (state_nxt == HOLD);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        counter <= '0;
                        armed   <= 1'b0;
                    end
                end
                LAUNCH: counter <= CNT_W'(1);
                RUN: begin
                    if (eng_busy || !eng_valid) armed <= 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (complete) begin
                        rsp_data    <= eng_result;
                        rsp_cycles  <= counter;
                        rsp_timeout <= 1'b0;
                    end else if (expire) begin
                        rsp_data    <= '0;
                        rsp_cycles  <= TMO_CNT;
                        rsp_timeout <= 1'b1;
                    end else begin
                        // RUN always exits at TMO_CNT, so this never wraps.
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_launcher.sv
// Self-checking bench for calc_launcher (TIMEOUT_CYC=16). A small engine
// model answers each eng_start; expected responses are queued when a job is
// issued and compared as the DUT hands them downstream.
module tb_calc_launcher;

    localparam int DATA_W = 32;
    localparam int TMO    = 16;
    localparam int CNT_W  = 16;

    localparam int M_SILENT = 0;
    localparam int M_NORM   = 1;
    localparam int M_STALE  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              tmo;
        logic [CNT_W-1:0]  cycles;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              eng_start;
    logic              eng_busy;
    logic              eng_valid;
    logic [DATA_W-1:0] eng_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;
    logic [CNT_W-1:0]  rsp_cycles;
    logic              idle;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t sb[$];
    int   start_q[$];

    // Engine model controls
    int                eng_mode = M_SILENT;
    int                eng_lat  = 0;
    logic [DATA_W-1:0] eng_res  = '0;

    calc_launcher #(.DATA_W(DATA_W), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_result(eng_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: cycle 0 is the eng_start cycle. NORM: busy on cycles
    // 1..lat+1, valid+result on cycle lat+1. STALE: valid (0xDEADBEEF) held
    // through cycles 0..1, low from 2, fresh valid on cycle 7, busy never.
    initial begin : engine
        int ek;
        bit run_e;
        ek = 0;
        run_e = 0;
        eng_busy = 0; eng_valid = 0; eng_result = '0;
        forever begin
            @(posedge clk); #1;
            if (eng_start === 1'b1) begin
                ek = 0; run_e = 1;
            end else if (run_e) begin
                ek++;
            end
            if (run_e) begin
                case (eng_mode)
                    M_NORM: begin
                        eng_busy   = (ek >= 1) && (ek <= eng_lat + 1);
                        eng_valid  = (ek == eng_lat + 1);
                        eng_result = (ek == eng_lat + 1) ? eng_res : '0;
                        if (ek > eng_lat + 1) run_e = 0;
                    end
                    M_STALE: begin
                        eng_busy   = 0;
                        eng_valid  = (ek <= 1) || (ek == 7);
                        eng_result = (ek <= 1) ? 32'hDEAD_BEEF : (ek == 7) ? eng_res : '0;
                        if (ek > 7) run_e = 0;
                    end
                    default: begin
                        eng_busy = 0; eng_valid = 0; eng_result = '0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor and start-pulse log
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got data=%h tmo=%b cycles=%0d, required no response",
                         rsp_data, rsp_timeout, rsp_cycles);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({rsp_data, rsp_timeout, rsp_cycles} !== {e.data, e.tmo, e.cycles}) begin
                    n_err++;
                    $display("FAIL rsp: got data=%h tmo=%b cycles=%0d, required data=%h tmo=%b cycles=%0d",
                             rsp_data, rsp_timeout, rsp_cycles, e.data, e.tmo, e.cycles);
                end
            end
        end
        if (eng_start === 1'b1) start_q.push_back(cyc);
    end

    task automatic issue_job();
        int n = 0;
        @(posedge clk); #1 req_valid = 1;
        do begin @(negedge clk); n++; end while (req_ready !== 1'b1 && n < 200);
        if (req_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL issue: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        @(posedge clk); #1 req_valid = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({idle, req_ready, eng_start, rsp_valid} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_ctl: idle/req_ready/eng_start/rsp_valid=%b, required 1100",
                     {idle, req_ready, eng_start, rsp_valid});
        end
        n_vec++;
        if ({rsp_data, rsp_timeout, rsp_cycles} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp: data=%h tmo=%b cycles=%0d, required all 0",
                     rsp_data, rsp_timeout, rsp_cycles);
        end
        @(negedge clk) reset = 1;
    endtask

    task automatic test_nominal();
        int s0;
        eng_mode = M_NORM; eng_lat = 4; eng_res = 32'h0003_0000;
        s0 = start_q.size();
        sb.push_back('{32'h0003_0000, 1'b0, 16'd5});
        issue_job();
        drain("nominal");
        repeat (3) @(negedge clk);
        n_vec++;
        if (start_q.size() - s0 !== 1) begin
            n_err++;
            $display("FAIL nominal_starts: %0d eng_start pulses, required 1", start_q.size() - s0);
        end
    endtask

    task automatic test_stale();
        @(posedge clk); #1;
        eng_mode = M_STALE; eng_res = 32'h0001_8000;
        eng_valid = 1; eng_result = 32'hDEAD_BEEF;
        sb.push_back('{32'h0001_8000, 1'b0, 16'd7});
        issue_job();
        drain("stale");
    endtask

    task automatic test_timeout();
        int n = 0;
        eng_mode = M_SILENT;
        sb.push_back('{32'h0, 1'b1, 16'(TMO)});
        issue_job();
        @(negedge clk);
        n_vec++;
        if (eng_start !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_start: eng_start=%b, required 1", eng_start);
        end
        do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 40);
        n_vec++;
        if (n !== TMO + 1) begin
            n_err++;
            $display("FAIL timeout_latency: response %0d cycles after start, required %0d", n, TMO + 1);
        end
        drain("timeout");
        // A normal job right after the abort
        eng_mode = M_NORM; eng_lat = 2; eng_res = 32'h0001_2345;
        sb.push_back('{32'h0001_2345, 1'b0, 16'd3});
        issue_job();
        drain("post_timeout");
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        rsp_ready = 0;
        eng_mode = M_NORM; eng_lat = 1; eng_res = 32'hABCD_0000;
        sb.push_back('{32'hABCD_0000, 1'b0, 16'd2});
        issue_job();
        do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 40);
        req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            if (!(rsp_valid === 1'b1 && rsp_data === 32'hABCD_0000 && rsp_cycles === 16'd2 &&
                  rsp_timeout === 1'b0 && req_ready === 1'b0 && eng_start === 1'b0)) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad);
        end
        eng_res = 32'h0000_0777;
        sb.push_back('{32'h0000_0777, 1'b0, 16'd2});
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);   // handshake cycle
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_bypass: req_ready=%b in handshake cycle, required 0", req_ready);
        end
        @(negedge clk);   // IDLE: second request accepted here
        n_vec++;
        if ({idle, eng_start} !== 2'b10) begin
            n_err++;
            $display("FAIL backpressure_idle: idle/eng_start=%b, required 10", {idle, eng_start});
        end
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        n_vec++;
        if (eng_start !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_start: eng_start=%b, required 1", eng_start);
        end
        drain("backpressure");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        eng_mode = M_NORM; eng_lat = 3; eng_res = 32'h0004_0000;
        repeat (3) sb.push_back('{32'h0004_0000, 1'b0, 16'd4});
        @(posedge clk); #1;
        start_q.delete();
        req_valid = 1;
        while (start_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
        req_valid = 0;
        n_vec++;
        if (start_q.size() < 3) begin
            n_err++;
            $display("FAIL b2b_starts: %0d pulses, required 3", start_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (start_q[i] - start_q[i-1] !== 7) begin
                    n_err++;
                    $display("FAIL b2b_spacing%0d: %0d cycles, required 7", i, start_q[i] - start_q[i-1]);
                end
            end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        eng_mode = M_SILENT;
        issue_job();
        repeat (5) @(negedge clk);   // now in RUN with counter=4
        #1 reset = 0;
        #1;
        n_vec++;
        if ({eng_start, rsp_valid, idle, req_ready} !== 4'b0011) begin
            n_err++;
            $display("FAIL midrun_reset: eng_start/rsp_valid/idle/req_ready=%b, required 0011",
                     {eng_start, rsp_valid, idle, req_ready});
        end
        n_vec++;
        if ({rsp_data, rsp_timeout, rsp_cycles} !== '0) begin
            n_err++;
            $display("FAIL midrun_rsp: data=%h tmo=%b cycles=%0d, required all 0",
                     rsp_data, rsp_timeout, rsp_cycles);
        end
        @(negedge clk) reset = 1;
        for (int i = 0; i < TMO + 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL midrun_noresp: rsp_valid high %0d cycles, required 0", bad);
        end
        eng_mode = M_NORM; eng_lat = 0; eng_res = 32'h0000_0055;
        sb.push_back('{32'h0000_0055, 1'b0, 16'd1});
        issue_job();
        drain("midrun_next");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 0; req_valid = 0; rsp_ready = 1;
        test_reset();
        test_nominal();
        test_stale();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
